// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: opcodes, writeback
// sources, fault codes, FSM states and the grouped control-strobe struct.
package cpu_ctrl_pkg;

  // Opcodes (low five bits of the IR opcode field).
  localparam logic [4:0] OpMv    = 5'b00000;
  localparam logic [4:0] OpAdd   = 5'b00001;
  localparam logic [4:0] OpSub   = 5'b00010;
  localparam logic [4:0] OpCmp   = 5'b00011;
  localparam logic [4:0] OpLd    = 5'b00100;
  localparam logic [4:0] OpSt    = 5'b00101;
  localparam logic [4:0] OpJr    = 5'b01000;
  localparam logic [4:0] OpJzr   = 5'b01001;
  localparam logic [4:0] OpJnr   = 5'b01010;
  localparam logic [4:0] OpCallr = 5'b01100;
  localparam logic [4:0] OpMvi   = 5'b10000;
  localparam logic [4:0] OpAddi  = 5'b10001;
  localparam logic [4:0] OpSubi  = 5'b10010;
  localparam logic [4:0] OpCmpi  = 5'b10011;
  localparam logic [4:0] OpMvhi  = 5'b10110;
  localparam logic [4:0] OpJ     = 5'b11000;
  localparam logic [4:0] OpJz    = 5'b11001;
  localparam logic [4:0] OpJn    = 5'b11010;
  localparam logic [4:0] OpCall  = 5'b11100;

  // Writeback source select.
  localparam logic [2:0] WbMem    = 3'b000;
  localparam logic [2:0] WbAlu    = 3'b001;
  localparam logic [2:0] WbPc     = 3'b010;
  localparam logic [2:0] WbRy     = 3'b011;
  localparam logic [2:0] WbImm8   = 3'b100;
  localparam logic [2:0] WbImm8Hi = 3'b101;

  // Fault codes.
  localparam logic [1:0] FcNone    = 2'b00;
  localparam logic [1:0] FcIllegal = 2'b01;
  localparam logic [1:0] FcTimeout = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StFault
  } state_e;

  // Branch condition evaluated against the flags in EXEC.
  typedef enum logic [1:0] {
    PcNever,
    PcAlways,
    PcIfZ,
    PcIfN
  } pc_cond_e;

  typedef struct packed {
    logic       is_mem;     // ld/st go through MEM instead of EXEC
    logic       mem_we;
    pc_cond_e   pc_cond;
    logic       br_src;
    logic       reg_write;
    logic       reg_dst;
    logic [2:0] wb_src;
    logic       alu_op;
    logic       alu_src;
    logic       ext_sel;
    logic       nz_write;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control-unit bus: sequencing inputs, IR/flag inputs, memory handshake and
// datapath strobes. master = control unit, slave = datapath/memory side.
interface cpu_ctrl_fsm_if #(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned CNT_W    = 16
);
  logic                run;
  logic                halt_req;
  logic [OPCODE_W-1:0] opcode;
  logic                flag_n;
  logic                flag_z;
  logic                mem_ready;

  logic                mem_req;
  logic                mem_sel;
  logic                mem_we;
  logic                ir_load;
  logic                pc_inc;
  logic                pc_load;
  logic                br_src;
  logic                reg_write;
  logic                reg_dst;
  logic [2:0]          wb_src;
  logic                alu_op;
  logic                alu_src;
  logic                ext_sel;
  logic                nz_write;
  logic                busy;
  logic                fault;
  logic [1:0]          fault_code;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  run, halt_req, opcode, flag_n, flag_z, mem_ready,
    output mem_req, mem_sel, mem_we, ir_load, pc_inc, pc_load, br_src, reg_write, reg_dst,
           wb_src, alu_op, alu_src, ext_sel, nz_write, busy, fault, fault_code, retired
  );

  modport slave (
    output run, halt_req, opcode, flag_n, flag_z, mem_ready,
    input  mem_req, mem_sel, mem_we, ir_load, pc_inc, pc_load, br_src, reg_write, reg_dst,
           wb_src, alu_op, alu_src, ext_sel, nz_write, busy, fault, fault_code, retired
  );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder: maps the IR opcode onto the control-strobe
// struct and flags opcodes outside the instruction table as illegal.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                legal
);

  logic upper_zero;
  logic known_op;

  // Bits above [4:0] exist only for wider opcode fields and must be zero.
  if (OPCODE_W > 5) begin : g_upper
    assign upper_zero = ~|opcode[OPCODE_W-1:5];
  end else begin : g_no_upper
    assign upper_zero = 1'b1;
  end

  assign legal = known_op & upper_zero;

  // Opcode table.
  always_comb begin
    ctrl     = '0;
    known_op = 1'b1;
    case (opcode[4:0])
      OpMv:    begin ctrl.reg_write = 1'b1; ctrl.wb_src = WbRy; end
      OpAdd, OpSub, OpAddi, OpSubi: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_src    = WbAlu;
        ctrl.alu_op    = opcode[1];
        ctrl.alu_src   = opcode[4];
        ctrl.nz_write  = 1'b1;
      end
      OpCmp, OpCmpi: begin
        ctrl.alu_op   = 1'b1;
        ctrl.alu_src  = opcode[4];
        ctrl.nz_write = 1'b1;
      end
      OpMvi:   begin ctrl.reg_write = 1'b1; ctrl.wb_src = WbImm8; end
      OpMvhi:  begin ctrl.reg_write = 1'b1; ctrl.wb_src = WbImm8Hi; end
      OpLd:    begin ctrl.is_mem = 1'b1; ctrl.reg_write = 1'b1; ctrl.wb_src = WbMem; end
      OpSt:    begin ctrl.is_mem = 1'b1; ctrl.mem_we = 1'b1; end
      OpJr:    ctrl.pc_cond = PcAlways;
      OpJzr:   ctrl.pc_cond = PcIfZ;
      OpJnr:   ctrl.pc_cond = PcIfN;
      OpJ:     begin ctrl.pc_cond = PcAlways; ctrl.br_src = 1'b1; ctrl.ext_sel = 1'b1; end
      OpJz:    begin ctrl.pc_cond = PcIfZ;    ctrl.br_src = 1'b1; ctrl.ext_sel = 1'b1; end
      OpJn:    begin ctrl.pc_cond = PcIfN;    ctrl.br_src = 1'b1; ctrl.ext_sel = 1'b1; end
      OpCallr, OpCall: begin
        // PC already holds the return address when EXEC writes it to R7.
        ctrl.pc_cond   = PcAlways;
        ctrl.br_src    = opcode[4];
        ctrl.ext_sel   = opcode[4];
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.wb_src    = WbPc;
      end
      default: known_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit: sequences FETCH, DECODE, EXEC and MEM, drives the
// datapath strobes for each opcode, counts retired instructions and latches a
// sticky fault on illegal opcodes or memory timeouts.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input logic            clk,
  input logic            reset,
  cpu_ctrl_fsm_if.master bus
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // wait_cnt counts cycles already spent waiting; the access faults on the
  // MEM_TIMEOUT-th request cycle without mem_ready.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q;
  ctrl_t            ctrl_q;
  ctrl_t            dec_ctrl;
  logic             dec_legal;
  logic [WaitW-1:0] wait_cnt;
  logic [CNT_W-1:0] retired_q;
  logic [1:0]       fault_code_q;

  cpu_ctrl_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode (bus.opcode),
    .ctrl   (dec_ctrl),
    .legal  (dec_legal)
  );

  // State sequencing, registered decode, wait counter, retire counter, fault code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ctrl_q       <= '0;
      wait_cnt     <= '0;
      retired_q    <= '0;
      fault_code_q <= FcNone;
    end else begin
      case (state_q)
        StIdle: if (bus.run) state_q <= StFetch;
        StFetch: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            state_q  <= StDecode;
          end else if (wait_cnt == WaitLast) begin
            wait_cnt     <= '0;
            fault_code_q <= FcTimeout;
            state_q      <= StFault;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        StDecode: begin
          if (!dec_legal) begin
            fault_code_q <= FcIllegal;
            state_q      <= StFault;
          end else begin
            ctrl_q  <= dec_ctrl;
            state_q <= dec_ctrl.is_mem ? StMem : StExec;
          end
        end
        StExec: begin
          retired_q <= retired_q + CNT_W'(1);
          state_q   <= bus.halt_req ? StIdle : StFetch;
        end
        StMem: begin
          if (bus.mem_ready) begin
            wait_cnt  <= '0;
            retired_q <= retired_q + CNT_W'(1);
            state_q   <= bus.halt_req ? StIdle : StFetch;
          end else if (wait_cnt == WaitLast) begin
            wait_cnt     <= '0;
            fault_code_q <= FcTimeout;
            state_q      <= StFault;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        StFault: state_q <= StFault;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes gated by state; flags and mem_ready act within the current cycle.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_sel    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_load    = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.br_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.wb_src     = WbMem;
    bus.alu_op     = 1'b0;
    bus.alu_src    = 1'b0;
    bus.ext_sel    = 1'b0;
    bus.nz_write   = 1'b0;
    bus.busy       = (state_q != StIdle) && (state_q != StFault);
    bus.fault      = (state_q == StFault);
    bus.fault_code = fault_code_q;
    bus.retired    = retired_q;
    case (state_q)
      StFetch: begin
        bus.mem_req = 1'b1;
        bus.ir_load = bus.mem_ready;
        bus.pc_inc  = bus.mem_ready;
      end
      StExec: begin
        if (!ctrl_q.is_mem) begin
          bus.br_src    = ctrl_q.br_src;
          bus.reg_write = ctrl_q.reg_write;
          bus.reg_dst   = ctrl_q.reg_dst;
          bus.wb_src    = ctrl_q.wb_src;
          bus.alu_op    = ctrl_q.alu_op;
          bus.alu_src   = ctrl_q.alu_src;
          bus.ext_sel   = ctrl_q.ext_sel;
          bus.nz_write  = ctrl_q.nz_write;
          case (ctrl_q.pc_cond)
            PcAlways: bus.pc_load = 1'b1;
            PcIfZ:    bus.pc_load = bus.flag_z;
            PcIfN:    bus.pc_load = bus.flag_n;
            default:  bus.pc_load = 1'b0;
          endcase
        end
      end
      StMem: begin
        bus.mem_req = 1'b1;
        bus.mem_sel = 1'b1;
        bus.mem_we  = ctrl_q.mem_we;
        if (bus.mem_ready) begin
          bus.reg_write = ctrl_q.reg_write;
          bus.wb_src    = ctrl_q.wb_src;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm. Each stimulus cycle pushes the expected
// output snapshot into a queue; a negedge monitor pops and compares.
module tb_cpu_ctrl_fsm;

  localparam int unsigned OpW   = 6;
  localparam int unsigned Tmo   = 4;
  localparam int unsigned CntW  = 2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_sel;
    logic       mem_we;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       br_src;
    logic       reg_write;
    logic       reg_dst;
    logic [2:0] wb_src;
    logic       alu_op;
    logic       alu_src;
    logic       ext_sel;
    logic       nz_write;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] retired;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  o;
  } exp_t;

  bit   clk;
  logic reset;
  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic [1:0] ret_m;

  cpu_ctrl_fsm_if #(.OPCODE_W(OpW), .CNT_W(CntW)) bus ();

  cpu_ctrl_fsm #(
    .OPCODE_W    (OpW),
    .MEM_TIMEOUT (Tmo),
    .CNT_W       (CntW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT snapshot against the next queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    obs_t got;
    got.mem_req = bus.mem_req;     got.mem_sel = bus.mem_sel;     got.mem_we = bus.mem_we;
    got.ir_load = bus.ir_load;     got.pc_inc = bus.pc_inc;       got.pc_load = bus.pc_load;
    got.br_src = bus.br_src;       got.reg_write = bus.reg_write; got.reg_dst = bus.reg_dst;
    got.wb_src = bus.wb_src;       got.alu_op = bus.alu_op;       got.alu_src = bus.alu_src;
    got.ext_sel = bus.ext_sel;     got.nz_write = bus.nz_write;   got.busy = bus.busy;
    got.fault = bus.fault;         got.fault_code = bus.fault_code;
    got.retired = bus.retired;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e.o) begin
        n_bad++;
        $display("FAIL %s: got %b required %b (t=%0t)", e.nm, got, e.o, $time);
      end
    end else if (bus.busy !== 1'b0 || bus.fault !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_activity: got busy=%b fault=%b required idle", bus.busy,
               bus.fault);
    end
  end

  function automatic obs_t mk(input logic [1:0] r);
    obs_t o = '0;
    o.retired = r;
    return o;
  endfunction

  function automatic obs_t fetch_o(input logic rdy, input logic [1:0] r);
    obs_t o = mk(r);
    o.busy = 1'b1; o.mem_req = 1'b1; o.ir_load = rdy; o.pc_inc = rdy;
    return o;
  endfunction

  function automatic obs_t dec_o(input logic [1:0] r);
    obs_t o = mk(r);
    o.busy = 1'b1;
    return o;
  endfunction

  // s = {pc_load, br_src, reg_write, reg_dst, wb_src[2:0], alu_op, alu_src, ext_sel, nz_write}
  function automatic obs_t exec_o(input logic [10:0] s, input logic [1:0] r);
    obs_t o = mk(r);
    o.busy = 1'b1;
    o.pc_load = s[10]; o.br_src = s[9]; o.reg_write = s[8]; o.reg_dst = s[7];
    o.wb_src = s[6:4]; o.alu_op = s[3]; o.alu_src = s[2]; o.ext_sel = s[1];
    o.nz_write = s[0];
    return o;
  endfunction

  function automatic obs_t mem_o(input logic we, input logic rdy, input logic ld,
                                 input logic [1:0] r);
    obs_t o = mk(r);
    o.busy = 1'b1; o.mem_req = 1'b1; o.mem_sel = 1'b1; o.mem_we = we;
    o.reg_write = ld & rdy;
    return o;
  endfunction

  function automatic obs_t fault_o(input logic [1:0] code, input logic [1:0] r);
    obs_t o = mk(r);
    o.fault = 1'b1; o.fault_code = code;
    return o;
  endfunction

  // One clock cycle: drive inputs just after the edge, queue the expected outputs.
  task automatic cyc(input logic rs, input logic rn, input logic hl, input logic [OpW-1:0] op,
                     input logic fn, input logic fz, input logic rd, input string nm,
                     input obs_t o);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; bus.run = rn; bus.halt_req = hl; bus.opcode = op;
    bus.flag_n = fn; bus.flag_z = fz; bus.mem_ready = rd;
    e.nm = nm;
    e.o  = o;
    exp_q.push_back(e);
  endtask

  // FETCH (ready at once), DECODE, EXEC; halt_req held on all three cycles.
  task automatic alu_instr(input logic [OpW-1:0] op, input logic fn, input logic fz,
                           input logic hl, input logic [10:0] s, input string nm);
    cyc(0, 0, hl, '0, 0, 0, 1, {nm, "/fetch"}, fetch_o(1, ret_m));
    cyc(0, 0, hl, op, 0, 0, 0, {nm, "/decode"}, dec_o(ret_m));
    cyc(0, 0, hl, op, fn, fz, 0, {nm, "/exec"}, exec_o(s, ret_m));
    ret_m = ret_m + 2'd1;
  endtask

  task automatic mem_instr(input logic [OpW-1:0] op, input logic we, input logic ld,
                           input int waits, input string nm);
    cyc(0, 0, 0, '0, 0, 0, 1, {nm, "/fetch"}, fetch_o(1, ret_m));
    cyc(0, 0, 0, op, 0, 0, 0, {nm, "/decode"}, dec_o(ret_m));
    for (int i = 0; i < waits; i++) cyc(0, 0, 0, op, 0, 0, 0, {nm, "/mem_wait"}, mem_o(we, 0, ld, ret_m));
    cyc(0, 0, 0, op, 0, 0, 1, {nm, "/mem_ready"}, mem_o(we, 1, ld, ret_m));
    ret_m = ret_m + 2'd1;
  endtask

  task automatic do_reset(input string nm);
    cyc(1, 0, 0, '0, 0, 0, 0, nm, mk(0));
    ret_m = 2'd0;
    cyc(0, 0, 0, '0, 0, 0, 0, {nm, "/idle"}, mk(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.run = 0; bus.halt_req = 0; bus.opcode = '0;
    bus.flag_n = 0; bus.flag_z = 0; bus.mem_ready = 0;
    n_cmp = 0; n_bad = 0; ret_m = 2'd0;

    cyc(1, 0, 0, '0, 0, 0, 0, "reset0", mk(0));
    cyc(1, 1, 0, '0, 0, 0, 1, "reset1", mk(0));
    cyc(0, 1, 0, '0, 0, 0, 0, "idle_run", mk(0));

    alu_instr(6'b000001, 0, 0, 0, 11'b0_0_1_0_001_0_0_0_1, "add");
    mem_instr(6'b000100, 0, 1, 3, "ld_wait3");
    alu_instr(6'b011001, 0, 0, 0, 11'b0_1_0_0_000_0_0_1_0, "jz_nt");
    alu_instr(6'b011001, 0, 1, 0, 11'b1_1_0_0_000_0_0_1_0, "jz_t");
    // Retired wraps to 0 here; call halts at the instruction boundary.
    alu_instr(6'b011100, 0, 0, 1, 11'b1_1_1_1_010_0_0_1_0, "call_halt");
    cyc(0, 0, 0, '0, 0, 0, 1, "idle_hold0", mk(ret_m));
    cyc(0, 0, 1, '0, 0, 0, 1, "idle_hold1", mk(ret_m));
    cyc(0, 1, 0, '0, 0, 0, 0, "idle_run2", mk(ret_m));

    alu_instr(6'b001010, 1, 0, 0, 11'b1_0_0_0_000_0_0_0_0, "jnr_t");
    mem_instr(6'b000101, 1, 0, 0, "st");
    alu_instr(6'b010000, 0, 0, 0, 11'b0_0_1_0_100_0_0_0_0, "mvi");
    alu_instr(6'b010010, 0, 0, 0, 11'b0_0_1_0_001_1_1_0_1, "subi");
    alu_instr(6'b000011, 0, 0, 0, 11'b0_0_0_0_000_1_0_0_1, "cmp");

    // Reset mid-MEM: outputs must clear within the same cycle.
    cyc(0, 0, 0, '0, 0, 0, 1, "rstmem/fetch", fetch_o(1, ret_m));
    cyc(0, 0, 0, 6'b000100, 0, 0, 0, "rstmem/decode", dec_o(ret_m));
    cyc(0, 0, 0, 6'b000100, 0, 0, 0, "rstmem/mem", mem_o(0, 0, 1, ret_m));
    do_reset("rstmem/reset");

    // Illegal low opcode; fault is sticky against run/ready/halt.
    cyc(0, 1, 0, '0, 0, 0, 0, "ill/idle_run", mk(0));
    cyc(0, 0, 0, '0, 0, 0, 1, "ill/fetch", fetch_o(1, 0));
    cyc(0, 0, 0, 6'b000111, 0, 0, 0, "ill/decode", dec_o(0));
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 6'b000001, 1, 1, 1, "ill/fault", fault_o(2'b01, 0));
    do_reset("ill/reset");

    // Nonzero upper opcode bit.
    cyc(0, 1, 0, '0, 0, 0, 0, "hi/idle_run", mk(0));
    cyc(0, 0, 0, '0, 0, 0, 1, "hi/fetch", fetch_o(1, 0));
    cyc(0, 0, 0, 6'b100001, 0, 0, 0, "hi/decode", dec_o(0));
    cyc(0, 0, 0, 6'b100001, 0, 0, 0, "hi/fault", fault_o(2'b01, 0));
    do_reset("hi/reset");

    // Fetch timeout: exactly Tmo request cycles, then fault.
    cyc(0, 1, 0, '0, 0, 0, 0, "ftmo/idle_run", mk(0));
    for (int i = 0; i < Tmo; i++) cyc(0, 0, 0, '0, 0, 0, 0, "ftmo/fetch_wait", fetch_o(0, 0));
    cyc(0, 0, 0, '0, 0, 0, 1, "ftmo/fault", fault_o(2'b10, 0));
    cyc(0, 0, 0, '0, 0, 0, 1, "ftmo/fault_hold", fault_o(2'b10, 0));
    do_reset("ftmo/reset");

    // Data-access timeout.
    cyc(0, 1, 0, '0, 0, 0, 0, "mtmo/idle_run", mk(0));
    cyc(0, 0, 0, '0, 0, 0, 1, "mtmo/fetch", fetch_o(1, 0));
    cyc(0, 0, 0, 6'b000100, 0, 0, 0, "mtmo/decode", dec_o(0));
    for (int i = 0; i < Tmo; i++) cyc(0, 0, 0, 6'b000100, 0, 0, 0, "mtmo/mem_wait", mem_o(0, 0, 1, 0));
    cyc(0, 0, 0, '0, 0, 0, 0, "mtmo/fault", fault_o(2'b10, 0));
    do_reset("mtmo/reset");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
